// File: rtl/studio2_keypad.sv
// Studio II keypad front end: tracks PS/2 and external key state per pad,
// holds the CPU key-select latch and drives the active-low EF flags.
module studio2_keypad #(
    parameter int          NUM_PADS   = 2,
    parameter int          KEYS       = 10,
    parameter int          SEL_PORT   = 2,
    parameter logic [15:0] TICK_DIV   = 16'd35795,
    parameter logic [3:0]  HOLD_TICKS = 4'd3
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic [10:0]             ps2_key,
    input  logic [2:0]              io_n,
    input  logic                    io_out,
    input  logic [7:0]              io_dout,
    input  logic                    efx,
    input  logic [NUM_PADS*16-1:0]  pad_ext,
    output logic [3:0]              ef,
    output logic [3:0]              key_sel,
    output logic [NUM_PADS*16-1:0]  pad_state
);

    localparam logic [15:0] KEY_MASK = 16'((32'd1 << KEYS) - 32'd1);

    logic                   tog_q;
    logic [2:0][15:0]       raw_q, raw_d;
    logic [3:0]             hold_q [3][16];
    logic [3:0]             hold_d [3][16];
    logic [15:0]            presc_q, presc_d;
    logic [3:0]             key_sel_q, key_sel_d;
    logic [3:0]             ef_q, ef_d;
    logic [NUM_PADS*16-1:0] pad_state_q, pad_state_d;

    logic        tick;
    logic [6:0]  map_word;
    logic        map_hit;
    logic [1:0]  map_pad;
    logic [3:0]  map_key;
    logic        key_event;
    logic [47:0] ext_all;
    logic [47:0] eff_flat;
    logic [15:0] hold_nz [3];
    logic [15:0] eff [3];
    logic        unused_dout;

    // Scan-code lookup, packed as {hit, pad, key}; pad2 has no PS/2 keys.
    function automatic logic [6:0] map_code(input logic [7:0] code);
        case (code)
            8'h45: return {1'b1, 2'd0, 4'd0};
            8'h16: return {1'b1, 2'd0, 4'd1};
            8'h1E: return {1'b1, 2'd0, 4'd2};
            8'h26: return {1'b1, 2'd0, 4'd3};
            8'h25: return {1'b1, 2'd0, 4'd4};
            8'h2E: return {1'b1, 2'd0, 4'd5};
            8'h36: return {1'b1, 2'd0, 4'd6};
            8'h3D: return {1'b1, 2'd0, 4'd7};
            8'h3E: return {1'b1, 2'd0, 4'd8};
            8'h46: return {1'b1, 2'd0, 4'd9};
            8'h70: return {1'b1, 2'd1, 4'd0};
            8'h69: return {1'b1, 2'd1, 4'd1};
            8'h72: return {1'b1, 2'd1, 4'd2};
            8'h7A: return {1'b1, 2'd1, 4'd3};
            8'h6B: return {1'b1, 2'd1, 4'd4};
            8'h73: return {1'b1, 2'd1, 4'd5};
            8'h74: return {1'b1, 2'd1, 4'd6};
            8'h6C: return {1'b1, 2'd1, 4'd7};
            8'h75: return {1'b1, 2'd1, 4'd8};
            8'h7D: return {1'b1, 2'd1, 4'd9};
            default: return 7'd0;
        endcase
    endfunction

    assign unused_dout = ^io_dout[7:4];
    assign map_word    = map_code(ps2_key[7:0]);
    assign map_hit     = map_word[6];
    assign map_pad     = map_word[5:4];
    assign map_key     = map_word[3:0];
    assign key_event   = (ps2_key[10] != tog_q) && !ps2_key[8] && map_hit &&
                         (int'(map_pad) < NUM_PADS) && (int'(map_key) < KEYS);
    assign tick        = (presc_q == TICK_DIV - 16'd1);
    assign presc_d     = tick ? 16'd0 : presc_q + 16'd1;
    assign ext_all     = 48'(pad_ext);

    // Hold counters age on each tick; a make in the same cycle reloads instead.
    always_comb begin
        raw_d = raw_q;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 16; k++) begin
                hold_d[p][k] = hold_q[p][k];
                if (tick && hold_q[p][k] != 4'd0)
                    hold_d[p][k] = hold_q[p][k] - 4'd1;
            end
        end
        if (key_event) begin
            if (ps2_key[9]) begin
                raw_d[map_pad][map_key]  = 1'b1;
                hold_d[map_pad][map_key] = HOLD_TICKS;
            end else begin
                raw_d[map_pad][map_key]  = 1'b0;
            end
        end
    end

    always_comb begin
        eff_flat = '0;
        for (int p = 0; p < 3; p++) begin
            hold_nz[p] = '0;
            for (int k = 0; k < 16; k++)
                hold_nz[p][k] = (hold_q[p][k] != 4'd0);
            eff[p] = (raw_q[p] | hold_nz[p] | ext_all[p*16 +: 16]) & KEY_MASK;
            if (p >= NUM_PADS)
                eff[p] = '0;
            eff_flat[p*16 +: 16] = eff[p];
        end
    end

    assign key_sel_d   = (io_out && io_n == 3'(SEL_PORT)) ? io_dout[3:0] : key_sel_q;
    assign ef_d        = {~eff[1][key_sel_q], ~eff[0][key_sel_q], ~eff[2][key_sel_q], efx};
    assign pad_state_d = eff_flat[NUM_PADS*16-1:0];

    always_ff @(posedge clk_sys) begin
        tog_q <= ps2_key[10];
        if (reset) begin
            raw_q       <= '0;
            presc_q     <= '0;
            key_sel_q   <= '0;
            ef_q        <= 4'b1111;
            pad_state_q <= '0;
            for (int p = 0; p < 3; p++)
                for (int k = 0; k < 16; k++)
                    hold_q[p][k] <= '0;
        end else begin
            raw_q       <= raw_d;
            presc_q     <= presc_d;
            key_sel_q   <= key_sel_d;
            ef_q        <= ef_d;
            pad_state_q <= pad_state_d;
            for (int p = 0; p < 3; p++)
                for (int k = 0; k < 16; k++)
                    hold_q[p][k] <= hold_d[p][k];
        end
    end

    assign ef        = ef_q;
    assign key_sel   = key_sel_q;
    assign pad_state = pad_state_q;

endmodule

// File: tb/tb_studio2_keypad.sv
// Bench for studio2_keypad: two differently parameterised instances checked every
// cycle against a tick-count model, plus directed literal checks.
module tb_studio2_keypad;

    logic        clkSys = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] ps2Key = '0;
    logic [2:0]  ioN = '0;
    logic        ioOut = 1'b0;
    logic [7:0]  ioDout = '0;
    logic        efx = 1'b1;
    logic [47:0] padExt = '0;

    logic [3:0]  ef0, ef1, ks0, ks1;
    logic [47:0] ps0;
    logic [31:0] ps1;

    int vectors = 0;
    int failures = 0;
    bit checkOn = 1'b0;

    int npArr[2] = '{3, 2};
    int kyArr[2] = '{10, 8};
    int tdArr[2] = '{4, 3};
    int htArr[2] = '{3, 0};
    logic [7:0] scanMap[2][10] = '{
        '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46},
        '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D}};

    studio2_keypad #(.NUM_PADS(3), .KEYS(10), .SEL_PORT(2), .TICK_DIV(16'd4), .HOLD_TICKS(4'd3)) dut0 (
        .clk_sys(clkSys), .reset(reset), .ps2_key(ps2Key), .io_n(ioN), .io_out(ioOut),
        .io_dout(ioDout), .efx(efx), .pad_ext(padExt), .ef(ef0), .key_sel(ks0), .pad_state(ps0));

    studio2_keypad #(.NUM_PADS(2), .KEYS(8), .SEL_PORT(2), .TICK_DIV(16'd3), .HOLD_TICKS(4'd0)) dut1 (
        .clk_sys(clkSys), .reset(reset), .ps2_key(ps2Key), .io_n(ioN), .io_out(ioOut),
        .io_dout(ioDout), .efx(efx), .pad_ext(padExt[31:0]), .ef(ef1), .key_sel(ks1), .pad_state(ps1));

    always #5 clkSys = ~clkSys;

    task automatic checkOutput(input string name, input logic [47:0] act, input logic [47:0] exp);
        vectors++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: hold expires once the global tick count reaches the value stored at the make.
    bit         mRaw[2][3][16];
    int         mExp[2][3][16];
    int         mTicks[2];
    int         mCyc[2];
    logic [3:0] mSel = '0;
    logic       mTog = 1'b0;
    logic [3:0] expEf[2];
    logic [47:0] expPad[2];

    always @(posedge clkSys) begin
        bit effB[3][16];
        bit isEvt;
        for (int i = 0; i < 2; i++) begin
            expEf[i] = 4'hF;
            expPad[i] = '0;
            if (!reset) begin
                for (int p = 0; p < 3; p++)
                    for (int k = 0; k < 16; k++) begin
                        effB[p][k] = (p < npArr[i]) && (k < kyArr[i]) &&
                                     (mRaw[i][p][k] || mTicks[i] < mExp[i][p][k] || padExt[p*16+k]);
                        expPad[i][p*16+k] = effB[p][k];
                    end
                expEf[i] = {~effB[1][mSel], ~effB[0][mSel], ~effB[2][mSel], efx};
            end
        end
        isEvt = (ps2Key[10] != mTog) && !ps2Key[8];
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                mTicks[i] = 0;
                mCyc[i] = 0;
                for (int p = 0; p < 3; p++)
                    for (int k = 0; k < 16; k++) begin
                        mRaw[i][p][k] = 1'b0;
                        mExp[i][p][k] = 0;
                    end
            end else begin
                if (mCyc[i] % tdArr[i] == tdArr[i] - 1)
                    mTicks[i]++;
                mCyc[i]++;
                if (isEvt)
                    for (int p = 0; p < 2; p++)
                        for (int k = 0; k < 10; k++)
                            if (scanMap[p][k] == ps2Key[7:0] && p < npArr[i] && k < kyArr[i]) begin
                                mRaw[i][p][k] = ps2Key[9];
                                if (ps2Key[9])
                                    mExp[i][p][k] = mTicks[i] + htArr[i];
                            end
            end
        end
        mTog = ps2Key[10];
        if (reset)
            mSel = '0;
        else if (ioOut && ioN == 3'd2)
            mSel = ioDout[3:0];
        #1;
        if (checkOn) begin
            checkOutput("ef0", {44'd0, ef0}, {44'd0, expEf[0]});
            checkOutput("ef1", {44'd0, ef1}, {44'd0, expEf[1]});
            checkOutput("padState0", ps0, expPad[0]);
            checkOutput("padState1", {16'd0, ps1}, {16'd0, expPad[1][31:0]});
            checkOutput("keySel0", {44'd0, ks0}, {44'd0, mSel});
            checkOutput("keySel1", {44'd0, ks1}, {44'd0, mSel});
        end
    end

    task automatic sendKey(input logic make, input logic ext, input logic [7:0] code);
        ps2Key = {~ps2Key[10], make, ext, code};
        @(negedge clkSys);
    endtask

    task automatic doOut(input logic [2:0] n, input logic [7:0] d);
        ioN = n;
        ioDout = d;
        ioOut = 1'b1;
        @(negedge clkSys);
        ioOut = 1'b0;
    endtask

    task automatic applyStimulus();
        int p, k;
        if ($urandom_range(0, 3) == 0) begin
            p = $urandom_range(0, 1);
            k = $urandom_range(0, 9);
            ps2Key = {~ps2Key[10], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : scanMap[p][k]};
        end
        ioOut = ($urandom_range(0, 5) == 0);
        ioN = ($urandom_range(0, 1) == 0) ? 3'd2 : 3'($urandom_range(0, 7));
        ioDout = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 11))};
        efx = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 7) == 0)
            padExt = ($urandom_range(0, 1) == 0) ? 48'd0 : (48'd1 << $urandom_range(0, 47));
        reset = ($urandom_range(0, 399) == 0);
    endtask

    initial begin
        int cnt0, cnt1;
        repeat (2) @(negedge clkSys);
        reset = 1'b0;
        checkOn = 1'b1;
        checkOutput("resetEf", {44'd0, ef0}, 48'hF);
        checkOutput("resetSel", {44'd0, ks0}, 48'h0);
        checkOutput("resetPad", ps0, 48'h0);

        sendKey(1'b1, 1'b0, 8'h16);
        repeat (3) @(negedge clkSys);
        checkOutput("efNoSel", {44'd0, ef0}, 48'hF);
        doOut(3'd2, 8'h01);
        checkOutput("selLoaded", {44'd0, ks0}, 48'h1);
        @(negedge clkSys);
        checkOutput("efSel1", {44'd0, ef0}, 48'hB);
        checkOutput("efSel1b", {44'd0, ef1}, 48'hB);
        checkOutput("padBit1", {47'd0, ps0[1]}, 48'h1);

        sendKey(1'b0, 1'b0, 8'h16);
        doOut(3'd2, 8'h00);
        doOut(3'd3, 8'h05);
        repeat (20) @(negedge clkSys);
        checkOutput("selOtherPort", {44'd0, ks0}, 48'h0);

        sendKey(1'b1, 1'b0, 8'h45);
        sendKey(1'b0, 1'b0, 8'h45);
        cnt0 = 0;
        cnt1 = 0;
        repeat (40) begin
            if (!ef0[2]) cnt0++;
            if (!ef1[2]) cnt1++;
            @(negedge clkSys);
        end
        vectors++;
        if (cnt0 < 9 || cnt0 > 12) begin
            failures++;
            $display("[TB] FAIL holdLen: got %0d cycles expected 9..12", cnt0);
        end
        checkOutput("holdZeroLen", 48'(cnt1), 48'd1);

        sendKey(1'b1, 1'b1, 8'h70);
        sendKey(1'b1, 1'b0, 8'h1C);
        repeat (3) @(negedge clkSys);
        checkOutput("ignoredPad", ps0, 48'h0);
        checkOutput("ignoredEf", {44'd0, ef0}, 48'hF);

        doOut(3'd2, 8'h07);
        padExt = 48'd1 << 39;
        @(negedge clkSys);
        checkOutput("extPad2", {44'd0, ef0}, 48'hD);
        checkOutput("extPad2b", {44'd0, ef1}, 48'hF);
        doOut(3'd2, 8'h0C);
        padExt = '1;
        @(negedge clkSys);
        checkOutput("selBeyondKeys", {44'd0, ef0}, 48'hF);
        checkOutput("padMask0", ps0, {3{16'h03FF}});
        checkOutput("padMask1", {16'd0, ps1}, {16'd0, {2{16'h00FF}}});
        padExt = '0;

        doOut(3'd2, 8'h00);
        efx = 1'b0;
        cnt0 = 0;
        repeat (3) begin
            @(negedge clkSys);
            if (!ef0[0]) cnt0++;
        end
        efx = 1'b1;
        repeat (5) begin
            @(negedge clkSys);
            if (!ef0[0]) cnt0++;
        end
        checkOutput("efxLow", 48'(cnt0), 48'd3);

        sendKey(1'b1, 1'b0, 8'h45);
        sendKey(1'b0, 1'b0, 8'h45);
        repeat (2) @(negedge clkSys);
        checkOutput("midHold", {47'd0, ef0[2]}, 48'h0);
        reset = 1'b1;
        @(negedge clkSys);
        checkOutput("resetMidEf", {44'd0, ef0}, 48'hF);
        checkOutput("resetMidPad", ps0, 48'h0);
        reset = 1'b0;

        repeat (3000) begin
            applyStimulus();
            @(negedge clkSys);
        end
        reset = 1'b0;
        @(negedge clkSys);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
        $finish;
    end

endmodule
